// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// pipe_addsub : pipelined signed adder/subtractor, one SEG-bit ripple segment
//               per stage, valid/ready flow control and optional saturation.
// Rev 1.0
// ============================================================================
module pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

   logic [STAGES-1:0] w_valid;
   logic [STAGES-1:0] w_load;
   logic              w_all_full;
   logic [WIDTH-1:0]  w_a_q  [STAGES];
   logic [WIDTH-1:0]  w_b_q  [STAGES];
   logic [WIDTH-1:0]  w_s_q  [STAGES];
   logic              w_c_q  [STAGES];
   logic              w_cm_q [STAGES];

   // A stage can load whenever any stage at or below it is empty, so bubbles
   // collapse even while the output is stalled.
   always_comb begin
      w_load     = '0;
      w_all_full = 1'b1;
      for (int k = 0; k < STAGES; k++) begin
         w_all_full = 1'b1;
         for (int j = k; j < STAGES; j++) begin
            w_all_full = w_all_full & w_valid[j];
         end
         w_load[k] = out_ready | ~w_all_full;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             w_up_v;
      logic [WIDTH-1:0] w_a_in;
      logic [WIDTH-1:0] w_b_in;
      logic [WIDTH-1:0] w_s_in;
      logic             w_c_in;
      logic [WIDTH-1:0] w_s_nxt;
      logic             w_c_nxt;
      logic             w_cm_nxt;
      logic             w_carry;
      logic             r_vld;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;
      logic             r_cm;

      if (k == 0) begin : g_first
         assign w_up_v = in_valid;
         assign w_a_in = a;
         assign w_b_in = sub ? ~b : b;
         assign w_c_in = sub ? ~cin : cin;
         assign w_s_in = '0;
      end else begin : g_next
         assign w_up_v = w_valid[k-1];
         assign w_a_in = w_a_q[k-1];
         assign w_b_in = w_b_q[k-1];
         assign w_c_in = w_c_q[k-1];
         assign w_s_in = w_s_q[k-1];
      end

      always_comb begin
         w_s_nxt  = w_s_in;
         w_carry  = w_c_in;
         w_cm_nxt = w_c_in;
         for (int i = k*SEG; i < (k+1)*SEG; i++) begin
            w_cm_nxt   = w_carry;
            w_s_nxt[i] = w_a_in[i] ^ w_b_in[i] ^ w_carry;
            w_carry    = (w_a_in[i] & w_b_in[i]) | (w_carry & (w_a_in[i] ^ w_b_in[i]));
         end
         w_c_nxt = w_carry;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_cm  <= 1'b0;
         end else if (w_load[k]) begin
            r_vld <= w_up_v;
            if (w_up_v) begin
               r_a  <= w_a_in;
               r_b  <= w_b_in;
               r_s  <= w_s_nxt;
               r_c  <= w_c_nxt;
               r_cm <= w_cm_nxt;
            end
         end
      end

      assign w_valid[k] = r_vld;
      assign w_a_q[k]   = r_a;
      assign w_b_q[k]   = r_b;
      assign w_s_q[k]   = r_s;
      assign w_c_q[k]   = r_c;
      assign w_cm_q[k]  = r_cm;
   end

   // Operand bits already consumed and the last stage's copies have no reader.
   logic w_unused_ok;
   assign w_unused_ok = ^{w_a_q[LAST], w_b_q[LAST]};

   assign in_ready  = w_load[0];
   assign out_valid = w_valid[LAST];
   assign cout      = w_c_q[LAST];
   assign ovf       = w_cm_q[LAST] ^ w_c_q[LAST];

   // On overflow the wrapped sign is opposite to A, so it selects the clamp.
   assign sum = ((SAT != 0) && ovf) ? (w_s_q[LAST][WIDTH-1] ? c_max_pos : c_min_neg)
                                    : w_s_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// tb_pipe_addsub : self-checking bench for pipe_addsub (16/4, 16/4 SAT,
//                  8/8 and 32/8 instances) against an arithmetic model.
// Rev 1.0
// ============================================================================
module tb_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready, cin, sub;
   logic [15:0] a16, b16;
   logic [7:0]  a8, b8;
   logic [31:0] a32, b32;
   logic        rdy16, ov16, c16, f16;
   logic [15:0] s16;
   logic        rdyS, ovS, cS, fS;
   logic [15:0] sS;
   logic        rdy8, ov8, c8, f8;
   logic [7:0]  s8;
   logic        rdy32, ov32, c32, f32;
   logic [31:0] s32;

   pipe_addsub #(.WIDTH(16), .SEG(4), .SAT(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .a(a16), .b(b16),
      .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(c16), .ovf(f16));
   pipe_addsub #(.WIDTH(16), .SEG(4), .SAT(1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyS), .a(a16), .b(b16),
      .cin(cin), .sub(sub), .out_valid(ovS), .out_ready(out_ready), .sum(sS), .cout(cS), .ovf(fS));
   pipe_addsub #(.WIDTH(8), .SEG(8), .SAT(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .a(a8), .b(b8),
      .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(c8), .ovf(f8));
   pipe_addsub #(.WIDTH(32), .SEG(8), .SAT(0)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .a(a32), .b(b32),
      .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(c32), .ovf(f32));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          t;
   } exp_t;

   exp_t q16[$];
   exp_t qS[$];
   exp_t q8[$];
   exp_t q32[$];

   // Result of the signed arithmetic, judged against the representable range.
   function automatic exp_t model(input int w, input bit satp, input logic [31:0] av,
                                  input logic [31:0] bv, input logic c, input logic s);
      exp_t   e;
      longint mask, au, bu, sa, sb, ci, r, mx, mn;
      mask = (longint'(1) <<< w) - 1;
      mx   = (longint'(1) <<< (w-1)) - 1;
      mn   = -mx - 1;
      au   = longint'(av) & mask;
      bu   = longint'(bv) & mask;
      sa   = (au > mx) ? au - (mask + 1) : au;
      sb   = (bu > mx) ? bu - (mask + 1) : bu;
      ci   = c ? 1 : 0;
      r    = s ? sa - sb - ci : sa + sb + ci;
      e.ovf  = (r > mx) || (r < mn);
      e.cout = s ? (au >= bu + ci) : (au + bu + ci > mask);
      if (satp && e.ovf) r = (r > mx) ? mx : mn;
      e.sum = 32'(r & mask);
      e.t   = cyc;
      return e;
   endfunction

   task automatic set_in(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic s);
      in_valid = v;
      a32 = av;       b32 = bv;
      a16 = av[15:0]; b16 = bv[15:0];
      a8  = av[7:0];  b8  = bv[7:0];
      cin = c;        sub = s;
   endtask

   task automatic record_accepts();
      if (in_valid && rdy16) q16.push_back(model(16, 1'b0, {16'b0, a16}, {16'b0, b16}, cin, sub));
      if (in_valid && rdyS)  qS.push_back(model(16, 1'b1, {16'b0, a16}, {16'b0, b16}, cin, sub));
      if (in_valid && rdy8)  q8.push_back(model(8, 1'b0, {24'b0, a8}, {24'b0, b8}, cin, sub));
      if (in_valid && rdy32) q32.push_back(model(32, 1'b0, a32, b32, cin, sub));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      q16.delete(); qS.delete(); q8.delete(); q32.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b0;
      set_in(1'b1, 32'h1234, 32'h4321, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ov16, ovS, ov8, ov32} !== 4'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b exp=0000", {ov16, ovS, ov8, ov32});
      end
      checks++;
      if (s16 !== 16'd0 || sS !== 16'd0 || s8 !== 8'd0 || s32 !== 32'd0) begin
         failures++; $display("FAIL reset_sum got=%h/%h/%h/%h exp=0", s16, sS, s8, s32);
      end
      checks++;
      if ({c16, cS, c8, c32, f16, fS, f8, f32} !== 8'b0) begin
         failures++; $display("FAIL reset_cout_ovf got=%b exp=0", {c16, cS, c8, c32, f16, fS, f8, f32});
      end
      rst_n = 1'b1;
      out_ready = 1'b1;
      set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({rdy16, rdyS, rdy8, rdy32} !== 4'b1111) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=1111", {rdy16, rdyS, rdy8, rdy32});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add_stream();
      int va[8] = '{0, 2, 127, -128, -32768, -127, -1, -2};
      int vb[8] = '{0, 3, 127, -128, 32767, -127, -1, -3};
      int vs[8] = '{0, 5, 254, -256, -1, -254, -2, -5};
      int sent = 0;
      int got  = 0;
      exp_t e;
      do_reset();
      for (int n = 0; n < 20; n++) begin
         if (sent < 8) set_in(1'b1, 32'(va[sent]), 32'(vb[sent]), 1'b0, 1'b0);
         else          set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         if (ov16) begin
            checks++;
            if (q16.size() == 0 || got >= 8) begin
               failures++; $display("FAIL add_extra_output got=%h exp=none", s16);
            end else begin
               e = q16.pop_front();
               if (s16 !== 16'(vs[got]) || f16 !== 1'b0 || (cyc - e.t) != 4) begin
                  failures++;
                  $display("FAIL add_stream[%0d] got sum=%h ovf=%b lat=%0d exp sum=%h ovf=0 lat=4",
                           got, s16, f16, cyc - e.t, 16'(vs[got]));
               end
               got++;
            end
         end
         if (sent < 8) begin
            checks++;
            if (rdy16 !== 1'b1) begin
               failures++; $display("FAIL add_in_ready got=%b exp=1", rdy16);
            end
         end
         if (in_valid && rdy16) sent++;
         record_accepts();
         @(posedge clk); #1;
      end
      checks++;
      if (got != 8) begin
         failures++; $display("FAIL add_count got=%0d exp=8", got);
      end
   endtask

   task automatic test_overflow_sub();
      int          va[6] = '{32767, -32768, 5, 0, 0, -32768};
      int          vb[6] = '{1, -1, 3, 1, 1, 1};
      logic        vc[6] = '{0, 0, 0, 0, 1, 0};
      logic        vsb[6] = '{0, 0, 1, 1, 1, 1};
      logic [15:0] ew[6] = '{16'h8000, 16'h7FFF, 16'h0002, 16'hFFFF, 16'hFFFE, 16'h7FFF};
      logic [15:0] es[6] = '{16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF, 16'hFFFE, 16'h8000};
      logic        ec[6] = '{0, 1, 1, 0, 0, 1};
      logic        eo[6] = '{1, 1, 0, 0, 0, 1};
      int sent = 0;
      int got  = 0;
      int gots = 0;
      do_reset();
      for (int n = 0; n < 16; n++) begin
         if (sent < 6) set_in(1'b1, 32'(va[sent]), 32'(vb[sent]), vc[sent], vsb[sent]);
         else          set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         if (ov16 && got < 6) begin
            checks++;
            if (s16 !== ew[got] || c16 !== ec[got] || f16 !== eo[got]) begin
               failures++;
               $display("FAIL wrap_vec[%0d] got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                        got, s16, c16, f16, ew[got], ec[got], eo[got]);
            end
            got++;
         end
         if (ovS && gots < 6) begin
            checks++;
            if (sS !== es[gots] || cS !== ec[gots] || fS !== eo[gots]) begin
               failures++;
               $display("FAIL sat_vec[%0d] got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                        gots, sS, cS, fS, es[gots], ec[gots], eo[gots]);
            end
            gots++;
         end
         if (in_valid && rdy16) sent++;
         @(posedge clk); #1;
      end
      checks++;
      if (got != 6 || gots != 6) begin
         failures++; $display("FAIL ovf_sub_count got=%0d/%0d exp=6/6", got, gots);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] opa[8], opb[8];
      logic        opc[8], ops[8];
      logic [15:0] hold_s;
      logic        hold_c, hold_f, exp_rdy;
      logic        stalled = 1'b0;
      int          sent = 0;
      int          got  = 0;
      exp_t        e;
      for (int i = 0; i < 8; i++) begin
         opa[i] = $urandom; opb[i] = $urandom;
         opc[i] = 1'($urandom_range(0, 1)); ops[i] = 1'($urandom_range(0, 1));
      end
      do_reset();
      for (int t = 0; t < 60 && got < 8; t++) begin
         out_ready = !(t >= 3 && t < 13);
         if (sent < 8 && !(t == 1 || t == 2 || t == 6)) set_in(1'b1, opa[sent], opb[sent], opc[sent], ops[sent]);
         else                                           set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         exp_rdy = out_ready || (q16.size() < 4);
         checks++;
         if (rdy16 !== exp_rdy) begin
            failures++; $display("FAIL bp_in_ready t=%0d got=%b exp=%b", t, rdy16, exp_rdy);
         end
         if (stalled) begin
            checks++;
            if (ov16 !== 1'b1 || s16 !== hold_s || c16 !== hold_c || f16 !== hold_f) begin
               failures++;
               $display("FAIL bp_stable t=%0d got v=%b sum=%h exp v=1 sum=%h", t, ov16, s16, hold_s);
            end
         end
         stalled = ov16 && !out_ready;
         hold_s = s16; hold_c = c16; hold_f = f16;
         if (ov16 && out_ready) begin
            checks++;
            if (q16.size() == 0) begin
               failures++; $display("FAIL bp_extra_output got=%h exp=none", s16);
            end else begin
               e = q16.pop_front();
               if ({s16, c16, f16} !== {e.sum[15:0], e.cout, e.ovf}) begin
                  failures++;
                  $display("FAIL bp_result[%0d] got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                           got, s16, c16, f16, e.sum[15:0], e.cout, e.ovf);
               end
               got++;
            end
         end
         if (in_valid && rdy16) sent++;
         record_accepts();
         @(posedge clk); #1;
      end
      checks++;
      if (got != 8 || q16.size() != 0) begin
         failures++; $display("FAIL bp_count got=%0d left=%0d exp=8/0", got, q16.size());
      end
   endtask

   task automatic test_reset_midstream();
      logic seen = 1'b0;
      do_reset();
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (n == 0)     set_in(1'b1, 32'h8000, 32'hFFFF, 1'b0, 1'b0);
         else if (n < 3) set_in(1'b1, $urandom, $urandom, 1'b0, 1'b0);
         else            set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         record_accepts();
         @(posedge clk); #1;
      end
      checks++;
      if (ov16 !== 1'b1 || s16 !== 16'h7FFF || c16 !== 1'b1 || f16 !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre got v=%b sum=%h cout=%b ovf=%b exp v=1 sum=7fff cout=1 ovf=1", ov16, s16, c16, f16);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (ov16 !== 1'b0 || s16 !== 16'd0 || c16 !== 1'b0 || f16 !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got v=%b sum=%h cout=%b ovf=%b exp all 0", ov16, s16, c16, f16);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      q16.delete(); qS.delete(); q8.delete(); q32.delete();
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checks++;
         if (ov16 !== 1'b0) begin
            failures++; $display("FAIL mid_ghost n=%0d got v=%b sum=%h exp v=0", n, ov16, s16);
         end
         @(posedge clk); #1;
      end
      for (int n = 0; n < 12 && !seen; n++) begin
         set_in(n == 0, 32'd100, 32'd23, 1'b0, 1'b1);
         @(negedge clk);
         if (ov16) begin
            checks++;
            if (s16 !== 16'd77 || n != 4) begin
               failures++; $display("FAIL mid_after got sum=%0d at=%0d exp sum=77 at=4", s16, n);
            end
            seen = 1'b1;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!seen) begin
         failures++; $display("FAIL mid_lost got=none exp=77");
      end
   endtask

   task automatic test_param_sweep();
      logic lat;
      exp_t e;
      do_reset();
      for (int n = 0; n < 1250; n++) begin
         lat = (n < 500);
         if (n < 1150) begin
            out_ready = lat ? 1'b1 : ($urandom_range(0, 3) != 0);
            set_in($urandom_range(0, 7) != 0, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            out_ready = 1'b1;
            set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         end
         @(negedge clk);
         if (ov8 && out_ready) begin
            checks++;
            if (q8.size() == 0) begin
               failures++; $display("FAIL sweep8_extra got=%h exp=none", s8);
            end else begin
               e = q8.pop_front();
               if ({s8, c8, f8} !== {e.sum[7:0], e.cout, e.ovf} || (lat && (cyc - e.t) != 1)) begin
                  failures++;
                  $display("FAIL sweep8 n=%0d got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=1",
                           n, s8, c8, f8, cyc - e.t, e.sum[7:0], e.cout, e.ovf);
               end
            end
         end
         if (ov32 && out_ready) begin
            checks++;
            if (q32.size() == 0) begin
               failures++; $display("FAIL sweep32_extra got=%h exp=none", s32);
            end else begin
               e = q32.pop_front();
               if ({s32, c32, f32} !== {e.sum, e.cout, e.ovf} || (lat && (cyc - e.t) != 4)) begin
                  failures++;
                  $display("FAIL sweep32 n=%0d got sum=%h cout=%b ovf=%b lat=%0d exp sum=%h cout=%b ovf=%b lat=4",
                           n, s32, c32, f32, cyc - e.t, e.sum, e.cout, e.ovf);
               end
            end
         end
         record_accepts();
         @(posedge clk); #1;
      end
      checks++;
      if (q8.size() != 0 || q32.size() != 0) begin
         failures++; $display("FAIL sweep_drain got left=%0d/%0d exp=0/0", q8.size(), q32.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add_stream();
      test_overflow_sub();
      test_backpressure();
      test_reset_midstream();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
